timer_bcd: RTL and testbench

Sequential binary-to-BCD converter for the timer's count. Sits between `timer` and the seven-segment display driver. Samples the 16-bit count whenever `t_valid` is high and the value has changed. Converts it to five packed BCD digits with the shift-add-3 (double-dabble) algorithm, one bit per clock, then presents the digits with a one-cycle valid pulse and a leading-zero blanking mask.

---
 rtl/timer_bcd.sv | 103 ++++++++++
 tb/tb_timer_bcd.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bcd.sv
// timer_bcd: sequential binary-to-BCD converter for the timer count.
// Converts one bit per clock using shift-add-3 (double-dabble), then
// presents five packed BCD digits with a one-cycle valid pulse and a
// leading-zero blanking mask for the seven-segment driver.
module timer_bcd #(
    parameter int CONV_BITS = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CONV_BITS-1:0] t_in,
    input  logic                 t_valid,
    output logic [19:0]          bcd_out,
    output logic                 bcd_valid,
    output logic [4:0]           lz_mask,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CONV_BITS-1:0] shift;
    logic [19:0]          scratch;
    logic [19:0]          scratch_adj;
    logic [4:0]           cnt;
    logic [CONV_BITS-1:0] last;
    logic                 first;
    logic                 start;

    // A new sample is taken on the first valid after reset, or on any change.
    assign start = t_valid && (first || (t_in != last));

    // Add-3 correction on every nibble >= 5, applied before the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Digit i is blank when it and every more-significant digit are zero;
    // the units digit is always shown.
    function automatic logic [4:0] lz_of(input logic [19:0] d);
        logic [4:0] m;
        m    = '0;
        m[4] = (d[19:16] == 4'd0);
        for (int i = 3; i >= 1; i--)
            m[i] = m[i+1] && (d[4*i +: 4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

    // Control FSM with registered outputs: IDLE samples, CONV iterates, DONE publishes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            last      <= '0;
            first     <= 1'b1;
            bcd_out   <= '0;
            lz_mask   <= 5'b11110;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift   <= t_in;
                        last    <= t_in;
                        scratch <= '0;
                        cnt     <= '0;
                        first   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    // Input MSB moves into the bottom of the BCD scratch.
                    {scratch, shift} <= {scratch_adj[18:0], shift, 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(CONV_BITS - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_out   <= scratch;
                    lz_mask   <= lz_of(scratch);
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_bcd.sv
// tb_timer_bcd: randomized and directed checks of timer_bcd against a
// decimal-arithmetic reference model.
module tb_timer_bcd;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] t_in;
    logic        t_valid;
    logic [19:0] bcd_out;
    logic        bcd_valid;
    logic [4:0]  lz_mask;
    logic        busy;

    int checks = 0;
    int passes = 0;

    // Reference model state
    bit          m_first;
    int          m_last;
    logic [19:0] m_bcd;
    logic [4:0]  m_lz;

    timer_bcd #(.CONV_BITS(16)) dut (
        .clock(clock), .reset(reset), .t_in(t_in), .t_valid(t_valid),
        .bcd_out(bcd_out), .bcd_valid(bcd_valid), .lz_mask(lz_mask), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] lz_exp(input int v);
        int nd;
        logic [4:0] m;
        nd = 1;
        if (v >= 10)    nd = 2;
        if (v >= 100)   nd = 3;
        if (v >= 1000)  nd = 4;
        if (v >= 10000) nd = 5;
        m = '0;
        for (int i = 1; i < 5; i++) m[i] = (i >= nd);
        return m;
    endfunction

    function automatic bit model_starts(input bit tv, input int v);
        return tv && (m_first || v != m_last);
    endfunction

    task automatic model_convert(input int v);
        m_first = 0;
        m_last  = v;
        m_bcd   = to_bcd(v);
        m_lz    = lz_exp(v);
    endtask

    task automatic model_reset();
        m_first = 1;
        m_last  = 0;
        m_bcd   = '0;
        m_lz    = 5'b11110;
    endtask

    // Counts posedges (sampled at the following negedge) until bcd_valid; n=-1 on timeout.
    task automatic wait_valid(input int limit, output int n, output int busy_n);
        n = -1;
        busy_n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (busy) busy_n++;
            if (bcd_valid) begin
                n = i;
                return;
            end
        end
    endtask

    // Counts bcd_valid pulses over a window of cycles.
    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(posedge clock);
            @(negedge clock);
            if (bcd_valid) pulses++;
        end
    endtask

    // Drives one value and checks a full conversion; n==18 means the pulse
    // arrives 17 edges after the sampling edge.
    task automatic test_convert(input string name, input int v);
        int n, bn;
        @(negedge clock);
        t_in = 16'(v);
        t_valid = 1'b1;
        wait_valid(40, n, bn);
        model_convert(v);
        checks++; if (n !== 18) $display("FAIL %s latency: got %0d want 18", name, n); else passes++;
        checks++; if (bcd_out !== m_bcd) $display("FAIL %s bcd_out: got %h want %h", name, bcd_out, m_bcd); else passes++;
        checks++; if (lz_mask !== m_lz) $display("FAIL %s lz_mask: got %b want %b", name, lz_mask, m_lz); else passes++;
        @(negedge clock);
        checks++; if (bcd_valid !== 1'b0) $display("FAIL %s pulse width: valid still %b", name, bcd_valid); else passes++;
    endtask

    task automatic test_reset();
        int n, bn, p;
        reset = 1'b0;
        t_valid = 1'b1;
        t_in = 16'd0;
        model_reset();
        repeat (3) @(negedge clock);
        checks++; if (bcd_out !== 20'h0) $display("FAIL reset bcd_out: got %h want 00000", bcd_out); else passes++;
        checks++; if (lz_mask !== 5'b11110) $display("FAIL reset lz_mask: got %b want 11110", lz_mask); else passes++;
        checks++; if (bcd_valid !== 1'b0) $display("FAIL reset bcd_valid: got %b want 0", bcd_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passes++;
        reset = 1'b1;
        wait_valid(40, n, bn);
        model_convert(0);
        checks++; if (n !== 18) $display("FAIL first_zero latency: got %0d want 18", n); else passes++;
        checks++; if (bcd_out !== m_bcd) $display("FAIL first_zero bcd_out: got %h want %h", bcd_out, m_bcd); else passes++;
        checks++; if (lz_mask !== m_lz) $display("FAIL first_zero lz_mask: got %b want %b", lz_mask, m_lz); else passes++;
        count_pulses(40, p);
        checks++; if (p !== 0) $display("FAIL zero_hold pulses: got %0d want 0", p); else passes++;
    endtask

    task automatic test_max();
        int n, bn;
        @(negedge clock);
        t_in = 16'd65535;
        wait_valid(40, n, bn);
        model_convert(65535);
        checks++; if (n !== 18) $display("FAIL max latency: got %0d want 18", n); else passes++;
        checks++; if (bn !== 17) $display("FAIL max busy cycles: got %0d want 17", bn); else passes++;
        checks++; if (bcd_out !== m_bcd) $display("FAIL max bcd_out: got %h want %h", bcd_out, m_bcd); else passes++;
        checks++; if (lz_mask !== m_lz) $display("FAIL max lz_mask: got %b want %b", lz_mask, m_lz); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL max busy after: got %b want 0", busy); else passes++;
    endtask

    // 100 is latched; 42 arrives mid-conversion and starts right after DONE.
    task automatic test_back_to_back();
        int n, bn;
        @(negedge clock);
        t_in = 16'd100;
        t_valid = 1'b1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (i == 5) t_in = 16'd42;
            if (bcd_valid) begin n = i; break; end
        end
        model_convert(100);
        checks++; if (n !== 18) $display("FAIL b2b first latency: got %0d want 18", n); else passes++;
        checks++; if (bcd_out !== m_bcd) $display("FAIL b2b first bcd_out: got %h want %h", bcd_out, m_bcd); else passes++;
        checks++; if (lz_mask !== m_lz) $display("FAIL b2b first lz_mask: got %b want %b", lz_mask, m_lz); else passes++;
        wait_valid(40, n, bn);
        model_convert(42);
        checks++; if (n !== 18) $display("FAIL b2b second spacing: got %0d want 18", n); else passes++;
        checks++; if (bcd_out !== m_bcd) $display("FAIL b2b second bcd_out: got %h want %h", bcd_out, m_bcd); else passes++;
        checks++; if (lz_mask !== m_lz) $display("FAIL b2b second lz_mask: got %b want %b", lz_mask, m_lz); else passes++;
    endtask

    task automatic test_valid_low();
        int p;
        @(negedge clock);
        t_valid = 1'b0;
        p = 0;
        for (int i = 0; i < 30; i++) begin
            t_in = 16'(9990 + (i % 10));
            @(posedge clock);
            @(negedge clock);
            if (bcd_valid) p++;
        end
        checks++; if (p !== 0) $display("FAIL valid_low pulses: got %0d want 0", p); else passes++;
        checks++; if (bcd_out !== m_bcd) $display("FAIL valid_low hold: got %h want %h", bcd_out, m_bcd); else passes++;
        test_convert("reassert_9999", 9999);
    endtask

    task automatic test_reset_mid();
        int p;
        @(negedge clock);
        t_in = 16'd500;
        t_valid = 1'b1;
        repeat (8) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (bcd_out !== 20'h0) $display("FAIL mid_reset bcd_out: got %h want 00000", bcd_out); else passes++;
        checks++; if (lz_mask !== 5'b11110) $display("FAIL mid_reset lz_mask: got %b want 11110", lz_mask); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_reset busy: got %b want 0", busy); else passes++;
        count_pulses(12, p);
        checks++; if (p !== 0) $display("FAIL mid_reset pulses: got %0d want 0", p); else passes++;
        reset = 1'b1;
        begin
            int n, bn;
            wait_valid(40, n, bn);
            model_convert(500);
            checks++; if (n !== 18) $display("FAIL after_reset latency: got %0d want 18", n); else passes++;
            checks++; if (bcd_out !== m_bcd) $display("FAIL after_reset bcd_out: got %h want %h", bcd_out, m_bcd); else passes++;
        end
    endtask

    task automatic test_random();
        int n, bn, p, v, r;
        bit tv;
        for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 3));
            v = (r == 0) ? m_last : int'($urandom_range(0, 65535));
            tv = (r != 1);
            @(negedge clock);
            t_in = 16'(v);
            t_valid = tv;
            if (model_starts(tv, v)) begin
                wait_valid(40, n, bn);
                model_convert(v);
                checks++; if (n !== 18) $display("FAIL rand[%0d] latency: got %0d want 18", k, n); else passes++;
                checks++; if (bcd_out !== m_bcd) $display("FAIL rand[%0d] bcd_out: got %h want %h", k, bcd_out, m_bcd); else passes++;
                checks++; if (lz_mask !== m_lz) $display("FAIL rand[%0d] lz_mask: got %b want %b", k, lz_mask, m_lz); else passes++;
            end else begin
                count_pulses(24, p);
                checks++; if (p !== 0) $display("FAIL rand[%0d] idle pulses: got %0d want 0", k, p); else passes++;
                checks++; if (bcd_out !== m_bcd) $display("FAIL rand[%0d] hold: got %h want %h", k, bcd_out, m_bcd); else passes++;
            end
        end
    endtask

    initial begin
        t_in = '0;
        t_valid = 1'b0;
        reset = 1'b0;
        test_reset();
        test_max();
        test_convert("val_1234", 1234);
        test_convert("val_7", 7);
        test_back_to_back();
        test_valid_low();
        test_reset_mid();
        test_convert("wrap_65535", 65535);
        test_convert("wrap_0", 0);
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
